// File: rtl/burst_mem_pkg.sv
// Shared types and widths for the burst memory responder.
package burst_mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD,
    DONE,
    ERR
  } burst_state_t;

  localparam int BURST_LEN_DEF = 8;
  localparam int DATA_W        = 8;
  localparam int ADDR_W        = 16;

endpackage

// File: rtl/burst_mem_ram.sv
// DEPTH x DATA_W storage: one write port, one registered read port.
// The array itself is never reset; only the read register is.
module burst_mem_ram
  import burst_mem_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  // rdata holds its last value between read beats
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_idx];
    end
  end

endmodule

// File: rtl/burst_mem_resp.sv
// Memory-side burst responder: stores write bursts, returns read bursts, checks burst protocol.
// Build option: define ADDR_SEQ_CHECK_EN to also flag non-contiguous beat addresses.
module burst_mem_resp
  import burst_mem_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int BURST_LEN = BURST_LEN_DEF
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [ADDR_W-1:0] address,
  input  logic              write_en,
  input  logic              read_en,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              burst_done,
  output logic              burst_err,
  output logic              busy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(BURST_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN);

  burst_state_t      state_reg;
  logic [CNT_W-1:0]  beat_cnt_reg;
  logic [ADDR_W-1:0] exp_addr_reg;

  logic rd_beat;
  logic dir_wr;
  logic own_en;
  logic opp_en;
  logic seq_ok;

  // On overlap the write wins and the read beat is dropped.
  assign rd_beat = read_en & ~write_en;
  assign dir_wr  = (state_reg == WR);
  assign own_en  = dir_wr ? write_en : read_en;
  assign opp_en  = dir_wr ? read_en  : write_en;

`ifdef ADDR_SEQ_CHECK_EN
  assign seq_ok = (address == exp_addr_reg);
`else
  assign seq_ok = 1'b1;
`endif

  burst_mem_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .n_rst   (n_rst),
    .wr_en   (write_en),
    .wr_idx  (address[IDX_W-1:0]),
    .wr_data (wdata),
    .rd_en   (rd_beat),
    .rd_idx  (address[IDX_W-1:0]),
    .rd_data (rdata)
  );

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_reg    <= IDLE;
      beat_cnt_reg <= '0;
      exp_addr_reg <= '0;
      rdata_valid  <= 1'b0;
      burst_done   <= 1'b0;
      burst_err    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      rdata_valid <= rd_beat;
      burst_done  <= 1'b0;
      burst_err   <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (write_en || read_en) begin
            beat_cnt_reg <= CNT_W'(1);
            exp_addr_reg <= write_en ? address + ADDR_W'(1) : address - ADDR_W'(1);
            busy         <= 1'b1;
            if (write_en && read_en) begin
              state_reg <= ERR;
              burst_err <= 1'b1;
            end else begin
              state_reg <= write_en ? WR : RD;
            end
          end
        end
        WR, RD: begin
          if (opp_en || (own_en && (beat_cnt_reg == LAST_BEAT || !seq_ok))) begin
            state_reg <= ERR;
            burst_err <= 1'b1;
          end else if (own_en) begin
            beat_cnt_reg <= beat_cnt_reg + CNT_W'(1);
            exp_addr_reg <= dir_wr ? exp_addr_reg + ADDR_W'(1) : exp_addr_reg - ADDR_W'(1);
          end else if (beat_cnt_reg == LAST_BEAT) begin
            state_reg  <= DONE;
            burst_done <= 1'b1;
          end else begin
            state_reg <= ERR;
            burst_err <= 1'b1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
        ERR: begin
          // Beats keep flowing to memory here; only checking is paused.
          if (!write_en && !read_en) begin
            state_reg <= IDLE;
            busy      <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
